// File: rtl/stereo_sched_pkg.sv
// Shared definitions for the stereo filter scheduler.
//   state_t    : scheduler FSM states, one frame in flight from IDLE back to IDLE
//   chan_left  : channel tag presented to the shared core for the left sample
//   chan_right : channel tag presented to the shared core for the right sample
package stereo_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND_L,
        WAIT_L,
        SEND_R,
        WAIT_R,
        OUT
    } state_t;

    localparam logic chan_left  = 1'b0;
    localparam logic chan_right = 1'b1;

endpackage

// File: rtl/stereo_filter_sched_wait_timer.sv
// Response timer for the WAIT states of the stereo scheduler.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   clear_i        : restart the count at zero (priority over en_i)
//   en_i           : count this cycle (high while waiting for the core)
//   done_o         : high in the enabled cycle whose count equals timeout_p-1,
//                    so the waiting state exits timeout_p cycles after entry
module wait_timer #(
    parameter int timeout_p = 255
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic en_i,
    output logic done_o
);

    localparam int cw = (timeout_p > 1) ? $clog2(timeout_p) : 1;
    localparam logic [cw-1:0] last = cw'(timeout_p - 1);

    logic [cw-1:0] count;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count <= '0;
        end else if (clear_i) begin
            count <= '0;
        end else if (en_i && count != last) begin
            // Saturates at the terminal value; the FSM leaves WAIT on done_o anyway.
            count <= count + 1'b1;
        end
    end

    assign done_o = en_i && (count == last);

endmodule

// File: rtl/stereo_filter_sched.sv
// Stereo scheduler around one shared mono filter core.
// Accepts a stereo frame, sends left then right through the core with a channel
// tag, collects both results and emits one stereo frame. Per-frame bypass skips
// the core; a missing core response times out and passes the input sample through.
//   clk_i, reset_i               : clock, asynchronous active-high reset
//   valid_i, ready_o             : stereo input handshake
//   data_left_i, data_right_i    : input samples
//   bypass_i                     : sampled at accept, 1 = skip the core
//   valid_o, ready_i             : stereo output handshake
//   data_left_o, data_right_o    : output samples
//   f_valid_o, f_ready_i         : sample handshake towards the core
//   f_data_o, f_chan_o           : sample and channel tag towards the core
//   f_valid_i, f_ready_o         : result handshake from the core
//   f_data_i                     : core result
//   frames_o                     : frames emitted, wraps
//   err_o                        : sticky timeout flag
// Every output is decoded from registered state only.
module stereo_filter_sched
    import stereo_sched_pkg::*;
#(
    parameter int width_p     = 24,
    parameter int timeout_p   = 255,
    parameter int cnt_width_p = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   valid_i,
    input  logic [width_p-1:0]     data_left_i,
    input  logic [width_p-1:0]     data_right_i,
    output logic                   ready_o,
    output logic                   valid_o,
    output logic [width_p-1:0]     data_left_o,
    output logic [width_p-1:0]     data_right_o,
    input  logic                   ready_i,
    input  logic                   bypass_i,
    output logic                   f_valid_o,
    output logic [width_p-1:0]     f_data_o,
    output logic                   f_chan_o,
    input  logic                   f_ready_i,
    input  logic                   f_valid_i,
    input  logic [width_p-1:0]     f_data_i,
    output logic                   f_ready_o,
    output logic [cnt_width_p-1:0] frames_o,
    output logic                   err_o
);

    state_t state, state_next;

    // Low while reset is held and for the first edge after release, so ready_o
    // can be low during reset without a combinational path from reset_i.
    logic run;

    logic [width_p-1:0]     left_in, right_in;
    logic [width_p-1:0]     left_out, right_out;
    logic [cnt_width_p-1:0] frames;
    logic                   err;

    logic accept;
    logic timer_clear;
    logic timer_done;
    logic timeout;

    // The count is held at zero through SEND_*, so it is zero on WAIT_* entry.
    assign timer_clear = (state == SEND_L) || (state == SEND_R);
    // A core result in the terminal cycle wins over the timeout.
    assign timeout     = timer_done && !f_valid_i;
    assign accept      = ready_o && valid_i;

    wait_timer #(
        .timeout_p(timeout_p)
    ) u_wait_timer (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(timer_clear),
        .en_i   (f_ready_o),
        .done_o (timer_done)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
            run   <= 1'b0;
        end else begin
            state <= state_next;
            run   <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch
        // can leave one unassigned and infer a latch.
        state_next = state;
        ready_o    = 1'b0;
        valid_o    = 1'b0;
        f_valid_o  = 1'b0;
        f_ready_o  = 1'b0;
        f_chan_o   = chan_left;
        f_data_o   = left_in;
        case (state)
            IDLE: begin
                ready_o = run;
                if (run && valid_i) state_next = bypass_i ? OUT : SEND_L;
            end
            SEND_L: begin
                f_valid_o = 1'b1;
                if (f_ready_i) state_next = WAIT_L;
            end
            WAIT_L: begin
                f_ready_o = 1'b1;
                if (f_valid_i || timeout) state_next = SEND_R;
            end
            SEND_R: begin
                f_valid_o = 1'b1;
                f_chan_o  = chan_right;
                f_data_o  = right_in;
                if (f_ready_i) state_next = WAIT_R;
            end
            WAIT_R: begin
                f_ready_o = 1'b1;
                f_chan_o  = chan_right;
                f_data_o  = right_in;
                if (f_valid_i || timeout) state_next = OUT;
            end
            OUT: begin
                valid_o = 1'b1;
                if (ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the sample registers are plain flops, not a memory, so they take
    // the asynchronous reset like the rest of the state.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            left_in   <= '0;
            right_in  <= '0;
            left_out  <= '0;
            right_out <= '0;
            frames    <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        left_in  <= data_left_i;
                        right_in <= data_right_i;
                        if (bypass_i) begin
                            left_out  <= data_left_i;
                            right_out <= data_right_i;
                        end
                    end
                end
                WAIT_L: begin
                    if (f_valid_i) begin
                        left_out <= f_data_i;
                    end else if (timeout) begin
                        left_out <= left_in;
                        err      <= 1'b1;
                    end
                end
                WAIT_R: begin
                    if (f_valid_i) begin
                        right_out <= f_data_i;
                    end else if (timeout) begin
                        right_out <= right_in;
                        err       <= 1'b1;
                    end
                end
                OUT: begin
                    if (ready_i) frames <= frames + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign data_left_o  = left_out;
    assign data_right_o = right_out;
    assign frames_o     = frames;
    assign err_o        = err;

endmodule

// File: tb/tb_stereo_filter_sched.sv
// Self-checking bench for stereo_filter_sched.
// A stub core (result = sample + 1, configurable accept and response delays, or
// silent) and a configurable sink surround the DUT. A frame-level model predicts
// every output frame, the core traffic order, latency, frames_o and err_o, and one
// negedge process compares the DUT against it every cycle.
module tb_stereo_filter_sched;
    import stereo_sched_pkg::*;

    localparam int W  = 24;
    localparam int TO = 4;
    localparam int CW = 8;

    typedef struct packed {
        logic [W-1:0] l;
        logic [W-1:0] r;
        logic         byp;
    } frame_t;

    typedef struct packed {
        logic [W-1:0] d;
        logic         ch;
    } send_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          valid_i = 1'b0, ready_i = 1'b0, bypass_i = 1'b0;
    logic [W-1:0]  data_left_i = '0, data_right_i = '0;
    logic          ready_o, valid_o;
    logic [W-1:0]  data_left_o, data_right_o;
    logic          f_valid_o, f_chan_o, f_ready_o;
    logic [W-1:0]  f_data_o;
    logic          f_ready_i = 1'b0, f_valid_i = 1'b0;
    logic [W-1:0]  f_data_i = '0;
    logic [CW-1:0] frames_o;
    logic          err_o;

    stereo_filter_sched #(
        .width_p(W), .timeout_p(TO), .cnt_width_p(CW)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .valid_i(valid_i), .data_left_i(data_left_i), .data_right_i(data_right_i),
        .ready_o(ready_o), .valid_o(valid_o),
        .data_left_o(data_left_o), .data_right_o(data_right_o),
        .ready_i(ready_i), .bypass_i(bypass_i),
        .f_valid_o(f_valid_o), .f_data_o(f_data_o), .f_chan_o(f_chan_o),
        .f_ready_i(f_ready_i), .f_valid_i(f_valid_i), .f_data_i(f_data_i),
        .f_ready_o(f_ready_o), .frames_o(frames_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stimulus / environment configuration, written by the main thread.
    frame_t src_q[$];
    int core_acc = 0, core_resp = 0;
    bit core_never = 0, core_rand = 0;
    int sink_stall = 0;
    bit sink_rand = 0;
    bit lat_on = 0;

    // Model and environment state, owned by the cycle process.
    frame_t       exp_q[$];
    send_t        send_q[$];
    int           model_frames = 0;
    bit           model_err = 0;
    bit           busy = 0, cur_byp = 0;
    int           acc_cnt = 0, stall_cnt = 0;
    bit           pend = 0;
    logic [W-1:0] pend_data = '0;
    int           resp_cnt = 0, resp_need = 0;
    bit           lat_armed = 0;
    int           lat_cnt = 0, lat_exp = 0, lat_meas = 0;
    bit           vo_hold = 0, fv_hold = 0;
    logic [W-1:0] hold_l = '0, hold_r = '0, hold_fd = '0;
    int           out_count = 0;
    logic [W-1:0] last_l = '0, last_r = '0;

    frame_t f;
    send_t  s;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            send_q.delete();
            busy = 0; cur_byp = 0; pend = 0; lat_armed = 0;
            vo_hold = 0; fv_hold = 0; acc_cnt = 0; stall_cnt = 0;
            model_frames = 0; model_err = 0;
            valid_i = 0; f_ready_i = 0; f_valid_i = 0; ready_i = 0;
        end else begin
            // Outputs held from last cycle must not have moved.
            if (vo_hold) begin
                check("out_valid_held", valid_o, 1);
                check("out_left_held", data_left_o, hold_l);
                check("out_right_held", data_right_o, hold_r);
            end
            if (fv_hold) begin
                check("core_valid_held", f_valid_o, 1);
                check("core_data_held", f_data_o, hold_fd);
            end
            check("frames", frames_o, model_frames[CW-1:0]);
            if (busy) check("no_accept_while_busy", ready_o, 0);
            else      check("no_output_while_idle", valid_o, 0);
            if (busy && cur_byp) check("bypass_no_core", f_valid_o, 0);
            if (lat_armed) begin
                lat_cnt++;
                if (valid_o) begin
                    lat_armed = 0;
                    lat_meas  = lat_cnt;
                    if (lat_on) check("latency", lat_cnt, lat_exp);
                end
            end

            // Drive this cycle's inputs.
            valid_i = (src_q.size() > 0);
            if (valid_i) begin
                data_left_i  = src_q[0].l;
                data_right_i = src_q[0].r;
                bypass_i     = src_q[0].byp;
            end else begin
                data_left_i  = W'($urandom);
                data_right_i = W'($urandom);
                bypass_i     = 1'($urandom);
            end
            f_ready_i = core_rand ? 1'($urandom) : (acc_cnt >= core_acc);
            f_valid_i = pend && (resp_cnt >= resp_need);
            f_data_i  = f_valid_i ? pend_data : W'($urandom);
            ready_i   = sink_rand ? 1'($urandom) : (stall_cnt >= sink_stall);

            // Handshakes that complete at the coming rising edge.
            if (valid_i && ready_o) begin
                f = src_q.pop_front();
                busy = 1;
                cur_byp = f.byp;
                if (f.byp) begin
                    exp_q.push_back(f);
                end else begin
                    send_q.push_back('{f.l, chan_left});
                    send_q.push_back('{f.r, chan_right});
                    if (core_never) begin
                        exp_q.push_back(f);
                        model_err = 1;
                    end else begin
                        exp_q.push_back('{f.l + W'(1), f.r + W'(1), 1'b0});
                    end
                end
                lat_exp = f.byp ? 1 : 1 + 2 * (core_acc + 1) + 2 * (core_never ? TO : core_resp + 1);
                lat_cnt = 0;
                lat_armed = 1;
            end

            if (f_valid_i && f_ready_o) pend = 0;
            else if (pend) resp_cnt++;

            if (f_valid_o && f_ready_i) begin
                if (send_q.size() == 0) begin
                    check("core_send_expected", send_q.size(), 1);
                end else begin
                    s = send_q.pop_front();
                    check("core_chan", f_chan_o, s.ch);
                    check("core_data", f_data_o, s.d);
                end
                if (!core_never) begin
                    pend      = 1;
                    pend_data = f_data_o + W'(1);
                    resp_cnt  = 0;
                    resp_need = core_rand ? int'($urandom_range(0, TO - 1)) : core_resp;
                end
                acc_cnt = 0;
            end else if (f_valid_o) begin
                acc_cnt++;
            end

            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    check("output_expected", exp_q.size(), 1);
                end else begin
                    f = exp_q.pop_front();
                    check("out_left", data_left_o, f.l);
                    check("out_right", data_right_o, f.r);
                end
                check("err_flag", err_o, model_err);
                last_l = data_left_o;
                last_r = data_right_o;
                out_count++;
                model_frames++;
                busy = 0;
                stall_cnt = 0;
            end else if (valid_o) begin
                stall_cnt++;
            end

            vo_hold = valid_o && !ready_i;
            hold_l  = data_left_o;
            hold_r  = data_right_o;
            fv_hold = f_valid_o && !f_ready_i;
            hold_fd = f_data_o;
        end
    end

    task automatic wait_out(input int target, input int budget);
        int n = 0;
        while (out_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (out_count < target) check("wait_out_budget", out_count, target);
        @(negedge clk);  // let frames_o settle after the last output edge
    endtask

    task automatic run_frame(input logic [W-1:0] l, input logic [W-1:0] r, input logic byp);
        int target;
        target = out_count + 1;
        src_q.push_back('{l, r, byp});
        wait_out(target, 200);
    endtask

    initial begin
        #1;
        check("rst_ready", ready_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_f_valid", f_valid_o, 0);
        check("rst_f_ready", f_ready_o, 0);
        check("rst_f_chan", f_chan_o, 0);
        check("rst_frames", frames_o, 0);
        check("rst_err", err_o, 0);
        check("rst_data_left", data_left_o, 0);
        repeat (2) @(negedge clk);
        #2 reset = 0;

        // Zero-wait core.
        lat_on = 1;
        run_frame(24'h000010, 24'h000020, 1'b0);
        check("t1_left", last_l, 24'h000011);
        check("t1_right", last_r, 24'h000021);
        check("t1_latency", lat_meas, 5);
        check("t1_frames", frames_o, 1);
        check("t1_err", err_o, 0);

        // Bypass with extreme values.
        run_frame(24'h7FFFFF, 24'h800000, 1'b1);
        check("t2_left", last_l, 24'h7FFFFF);
        check("t2_right", last_r, 24'h800000);
        check("t2_latency", lat_meas, 1);
        check("t2_frames", frames_o, 2);

        // Slow core: 7 cycles of f_ready_i low, response on the last WAIT cycle.
        core_acc = 7; core_resp = 3;
        run_frame(24'h000100, 24'hFFFFFF, 1'b0);
        check("t3_left", last_l, 24'h000101);
        check("t3_right", last_r, 24'h000000);
        check("t3_latency", lat_meas, 25);
        check("t3_err", err_o, 0);

        // Silent core: both channels time out and pass through.
        core_acc = 0; core_resp = 0; core_never = 1;
        run_frame(24'h000005, 24'h000006, 1'b0);
        check("t4_left", last_l, 24'h000005);
        check("t4_right", last_r, 24'h000006);
        check("t4_latency", lat_meas, 11);
        check("t4_err", err_o, 1);
        core_never = 0;
        run_frame(24'h000001, 24'h000002, 1'b0);
        check("t4b_left", last_l, 24'h000002);
        check("t4b_err_sticky", err_o, 1);
        check("t4b_frames", frames_o, 5);

        // Downstream stall of 10 cycles with the next frame already waiting.
        sink_stall = 10;
        begin
            int target;
            target = out_count + 2;
            src_q.push_back('{24'h000100, 24'h000200, 1'b0});
            src_q.push_back('{24'h000300, 24'h000400, 1'b1});
            wait_out(target, 200);
        end
        check("t5_left", last_l, 24'h000300);
        check("t5_frames", frames_o, 7);
        sink_stall = 0;

        // Asynchronous reset in the middle of WAIT_R.
        core_resp = 3;
        src_q.push_back('{24'h0000AA, 24'h0000BB, 1'b0});
        begin
            bit found = 0;
            for (int i = 0; i < 100 && !found; i++) begin
                @(negedge clk);
                if (f_ready_o && f_chan_o) found = 1;
            end
            check("t6_reached_wait_r", found, 1);
        end
        #2 reset = 1;
        #1;
        check("t6_valid", valid_o, 0);
        check("t6_f_valid", f_valid_o, 0);
        check("t6_f_ready", f_ready_o, 0);
        check("t6_ready", ready_o, 0);
        check("t6_frames", frames_o, 0);
        check("t6_err", err_o, 0);
        repeat (2) @(negedge clk);
        #2 reset = 0;
        core_resp = 0;
        run_frame(24'h123456, 24'h654321, 1'b0);
        check("t6b_left", last_l, 24'h123457);
        check("t6b_right", last_r, 24'h654322);
        check("t6b_frames", frames_o, 1);
        check("t6b_latency", lat_meas, 5);

        // Random traffic up to one short of the counter wrap.
        lat_on = 0; core_rand = 1; sink_rand = 1;
        begin
            int target;
            target = out_count + 254;
            for (int i = 0; i < 254; i++)
                src_q.push_back('{W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0)});
            wait_out(target, 20000);
        end
        check("wrap_pre", frames_o, 8'hFF);
        core_rand = 0; sink_rand = 0;
        run_frame(24'h000001, 24'h000002, 1'b1);
        check("wrap_post", frames_o, 8'h00);
        check("final_err", err_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
